// File: rtl/noise_sweep_sequencer_if.sv
// Bus between the test/control logic, the noise generator and the sweep
// sequencer. Grouping these lets a bench or parent bind the whole set at once.
//
// Signalling: there is no valid/ready pair on this bus. start, abort and
// sample_tick are single-cycle qualifiers that are sampled on every rising
// clock edge and are never back-pressured. measure_valid and done are
// registered one-cycle pulses that the receiver must take in that cycle.
// noise_en and noise_level are level outputs that hold until the next step
// change. dbg_state mirrors the sequencer's FSM state for observation only.
interface noise_sweep_sequencer_if;
  logic       start;
  logic       abort;
  logic       sample_tick;
  logic       noise_en;
  logic [3:0] noise_level;
  logic       measure_valid;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  // Control side: drives the commands and the sample strobe, observes results.
  modport master (
    output start, abort, sample_tick,
    input  noise_en, noise_level, measure_valid, busy, done, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  start, abort, sample_tick,
    output noise_en, noise_level, measure_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/noise_sweep_sequencer.sv
// Noise sweep sequencer: runs a clean baseline step and then ascending noise
// levels. Each step discards SETTLE_TICKS filter samples and then flags
// SAMPLES_PER_LEVEL samples as a measurement window. It is paced by
// sample_tick, and abort or rst ends a sweep at once without a done pulse.
module noise_sweep_sequencer #(
  parameter int unsigned SAMPLES_PER_LEVEL = 16,  // 1..255
  parameter int unsigned SETTLE_TICKS      = 4,   // 0..255
  parameter int unsigned LEVEL_STEP        = 2,   // 1..15
  parameter int unsigned LEVEL_MAX         = 15   // 0..15
) (
  input  logic                     clk,
  input  logic                     rst,
  noise_sweep_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE_TICKS);
  localparam logic [7:0] SAMPLES_C = 8'(SAMPLES_PER_LEVEL);
  localparam logic [4:0] STEP_C    = 5'(LEVEL_STEP);
  localparam logic [4:0] MAX_C     = 5'(LEVEL_MAX);
  // With no settle window a new step goes straight into measuring.
  localparam state_t     STEP_ENTRY = (SETTLE_TICKS == 0) ? MEASURE : SETTLE;

  state_t     state;
  logic [7:0] tick_cnt;
  logic [4:0] level;
  logic       noisy;
  logic       noise_en_r;
  logic [3:0] noise_level_r;
  logic       measure_valid_r;
  logic       busy_r;
  logic       done_r;

  logic [7:0] tick_next;
  logic [4:0] level_next;

  // Next counter and level values. level_next is 5 bits wide, so the
  // end-of-sweep comparison cannot wrap.
  always_comb begin
    tick_next  = tick_cnt + 8'd1;
    level_next = level + STEP_C;
  end

  // Sweep FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tick_cnt        <= 8'd0;
      level           <= 5'd0;
      noisy           <= 1'b0;
      noise_en_r      <= 1'b0;
      noise_level_r   <= 4'd0;
      measure_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      measure_valid_r <= 1'b0;
      done_r          <= 1'b0;
      if (bus.abort && (state != IDLE)) begin
        // Abort beats any tick or step advance in the same cycle.
        state         <= IDLE;
        tick_cnt      <= 8'd0;
        noise_en_r    <= 1'b0;
        noise_level_r <= 4'd0;
        busy_r        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state         <= STEP_ENTRY;
              tick_cnt      <= 8'd0;
              level         <= 5'd0;
              noisy         <= 1'b0;
              noise_en_r    <= 1'b0;
              noise_level_r <= 4'd0;
              busy_r        <= 1'b1;
            end
          end
          SETTLE: begin
            if (bus.sample_tick) begin
              if (tick_next == SETTLE_C) begin
                state    <= MEASURE;
                tick_cnt <= 8'd0;
              end else begin
                tick_cnt <= tick_next;
              end
            end
          end
          MEASURE: begin
            if (bus.sample_tick) begin
              measure_valid_r <= 1'b1;
              if (tick_next == SAMPLES_C) begin
                tick_cnt <= 8'd0;
                if (!noisy) begin
                  // The baseline step is done, so start with noise at level 0.
                  noisy         <= 1'b1;
                  level         <= 5'd0;
                  noise_en_r    <= 1'b1;
                  noise_level_r <= 4'd0;
                  state         <= STEP_ENTRY;
                end else if (level_next > MAX_C) begin
                  state         <= DONE;
                  done_r        <= 1'b1;
                  noise_en_r    <= 1'b0;
                  noise_level_r <= 4'd0;
                  busy_r        <= 1'b0;
                end else begin
                  level         <= level_next;
                  noise_level_r <= level_next[3:0];
                  state         <= STEP_ENTRY;
                end
              end else begin
                tick_cnt <= tick_next;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.noise_en      = noise_en_r;
  assign bus.noise_level   = noise_level_r;
  assign bus.measure_valid = measure_valid_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_noise_sweep_sequencer.sv
// Bench for noise_sweep_sequencer. Two instances share one stimulus stream:
// dut0 uses the default parameters, and dut1 uses SETTLE_TICKS=0,
// LEVEL_STEP=15, LEVEL_MAX=15. A step-list model predicts every output on
// every cycle. Literal checks pin the sweep lengths and boundary timing.
module tb_noise_sweep_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, sample_tick;

  noise_sweep_sequencer_if bus0 ();
  noise_sweep_sequencer_if bus1 ();

  assign bus0.start = start;  assign bus0.abort = abort;  assign bus0.sample_tick = sample_tick;
  assign bus1.start = start;  assign bus1.abort = abort;  assign bus1.sample_tick = sample_tick;

  noise_sweep_sequencer #(.SAMPLES_PER_LEVEL(16), .SETTLE_TICKS(4), .LEVEL_STEP(2), .LEVEL_MAX(15))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  noise_sweep_sequencer #(.SAMPLES_PER_LEVEL(16), .SETTLE_TICKS(0), .LEVEL_STEP(15), .LEVEL_MAX(15))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // ---------------- behavioural model ----------------
  // A sweep is a list of steps: step 0 is the baseline, and step k>=1 is
  // noise at level (k-1)*STEP. Each step takes settle+samples ticks, and
  // only ticks past the settle window are measured.
  int cfg_settle  [2] = '{4, 0};
  int cfg_samples [2] = '{16, 16};
  int cfg_step    [2] = '{2, 15};
  int cfg_max     [2] = '{15, 15};

  bit   m_active [2];
  bit   m_done   [2];
  int   m_stepi  [2];
  int   m_tick   [2];
  logic [7:0] exp_v [2];
  bit   model_live = 1'b0;

  function automatic int n_steps(int i);
    return 2 + cfg_max[i] / cfg_step[i];
  endfunction

  // Advance the model on each clock edge, using the same inputs the DUT samples.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic mv_e, en_e;
      int   lvl_e;
      mv_e = 1'b0;
      if (rst) begin
        m_active[i] = 0; m_done[i] = 0; m_stepi[i] = 0; m_tick[i] = 0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_active[i]) begin
        if (abort) begin
          m_active[i] = 0;
        end else if (sample_tick) begin
          m_tick[i] = m_tick[i] + 1;
          if (m_tick[i] > cfg_settle[i]) mv_e = 1'b1;
          if (m_tick[i] == cfg_settle[i] + cfg_samples[i]) begin
            m_tick[i]  = 0;
            m_stepi[i] = m_stepi[i] + 1;
            if (m_stepi[i] == n_steps(i)) begin
              m_active[i] = 0;
              m_done[i]   = 1;
            end
          end
        end
      end else if (start && !abort) begin
        m_active[i] = 1; m_stepi[i] = 0; m_tick[i] = 0;
      end
      en_e  = m_active[i] && (m_stepi[i] >= 1);
      lvl_e = en_e ? (m_stepi[i] - 1) * cfg_step[i] : 0;
      exp_v[i] = {en_e, 4'(lvl_e), mv_e, m_active[i], m_done[i]};
    end
    model_live = 1'b1;
  end

  // ---------------- comparison / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] act0, act1;
  assign act0 = {bus0.noise_en, bus0.noise_level, bus0.measure_valid, bus0.busy, bus0.done};
  assign act1 = {bus1.noise_en, bus1.noise_level, bus1.measure_valid, bus1.busy, bus1.done};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wait until away from the active edge, then compare both DUTs
  // against the model. Bits are {noise_en, noise_level[3:0], measure_valid, busy, done}.
  task automatic step_clk();
    @(negedge clk);
    if (model_live) begin
      n_cmp++;
      if (act0 !== exp_v[0]) begin
        n_err++;
        $display("FAIL model_dut0: got %b expected %b at %0t", act0, exp_v[0], $time);
      end
      n_cmp++;
      if (act1 !== exp_v[1]) begin
        n_err++;
        $display("FAIL model_dut1: got %b expected %b at %0t", act1, exp_v[1], $time);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int mv0, mv1, dn0, dn1, done_tick0, done_tick1;
  int en0_19, en0_20, lvl0_20, lvl0_39, lvl0_40, lvl1_16, en1_16, lvl1_32;

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; sample_tick = 1'b0;
    repeat (5) step_clk();
    check("reset_busy0", int'(bus0.busy), 0);
    check("reset_outs0", int'(act0), 0);
    rst = 1'b0;
    step_clk();
    check("start_busy0", int'(bus0.busy), 1);
    check("start_busy1", int'(bus1.busy), 1);
    start = 1'b0;

    // Default sweep paced at one tick every 3 cycles. Stray starts are
    // pulsed while both DUTs are mid-sweep.
    mv0 = 0; mv1 = 0; dn0 = 0; dn1 = 0; done_tick0 = 0; done_tick1 = 0;
    for (int k = 1; k <= 200; k++) begin
      sample_tick = 1'b1;
      step_clk();
      sample_tick = 1'b0;
      mv0 += int'(bus0.measure_valid); mv1 += int'(bus1.measure_valid);
      if (bus0.done) begin dn0++; done_tick0 = k; end
      if (bus1.done) begin dn1++; done_tick1 = k; end
      if (k == 19) begin en0_19 = int'(bus0.noise_en); lvl0_39 = 0; end
      if (k == 20) begin en0_20 = int'(bus0.noise_en); lvl0_20 = int'(bus0.noise_level); end
      if (k == 39) lvl0_39 = int'(bus0.noise_level);
      if (k == 40) lvl0_40 = int'(bus0.noise_level);
      if (k == 16) begin en1_16 = int'(bus1.noise_en); lvl1_16 = int'(bus1.noise_level); end
      if (k == 32) lvl1_32 = int'(bus1.noise_level);
      if (k == 10 || k == 30) start = 1'b1;
      step_clk();
      start = 1'b0;
      mv0 += int'(bus0.measure_valid); mv1 += int'(bus1.measure_valid);
      dn0 += int'(bus0.done); dn1 += int'(bus1.done);
      step_clk();
    end
    check("mv_count0", mv0, 144);
    check("done_count0", dn0, 1);
    check("done_tick0", done_tick0, 180);
    check("en_before_t20", en0_19, 0);
    check("en_at_t20", en0_20, 1);
    check("lvl_at_t20", lvl0_20, 0);
    check("lvl_at_t39", lvl0_39, 0);
    check("lvl_at_t40", lvl0_40, 2);
    check("mv_count1", mv1, 48);
    check("done_count1", dn1, 1);
    check("done_tick1", done_tick1, 48);
    check("en1_at_t16", en1_16, 1);
    check("lvl1_at_t16", lvl1_16, 0);
    check("lvl1_at_t32", lvl1_32, 15);

    // Abort arrives together with dut0's step-completing 20th tick.
    start = 1'b1; step_clk(); start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      sample_tick = 1'b1; step_clk(); sample_tick = 1'b0; step_clk();
    end
    sample_tick = 1'b1; abort = 1'b1;
    step_clk();
    sample_tick = 1'b0; abort = 1'b0;
    check("abort_outs0", int'(act0), 0);
    check("abort_outs1", int'(act1), 0);
    step_clk();
    check("abort_no_done0", int'(bus0.done), 0);
    start = 1'b1; step_clk(); start = 1'b0;
    check("restart_busy0", int'(bus0.busy), 1);
    check("restart_en0", int'(bus0.noise_en), 0);
    abort = 1'b1; step_clk(); abort = 1'b0;

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      rst         = (($urandom_range(0, 999)) == 0);
      start       = (($urandom_range(0, 19)) == 0);
      abort       = (($urandom_range(0, 149)) == 0);
      sample_tick = (($urandom_range(0, 2)) != 0);
      step_clk();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; sample_tick = 1'b0;
    step_clk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
